board_input_debounce: RTL

- Input-side counterpart to the board LED driver: conditions raw slide-switch and push-button pins into clean, clock-synchronous levels and single-cycle edge pulses.
- Sits between the top-level board pins and user logic. All outputs are in the clk100m domain.
- Per channel: 2-flop synchronizer, then a stability counter, then a registered level and registered rise/fall pulses.

---
 rtl/board_io_pkg.sv | 38 +++
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/board_input_debounce.sv | 34 +++
 3 files changed

// File: rtl/board_io_pkg.sv
// Board-level I/O constants shared by the pin conditioning logic and user logic.
// Also holds the debounce channel state type.
package board_io_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned DEBOUNCE_10MS = 1_000_000;
    localparam int unsigned N_SW          = 16;
    localparam int unsigned N_BTN         = 5;

    // Channel index map: switches first, then buttons.
    localparam int unsigned SW0  = 0;
    localparam int unsigned SW1  = 1;
    localparam int unsigned SW2  = 2;
    localparam int unsigned SW3  = 3;
    localparam int unsigned SW4  = 4;
    localparam int unsigned SW5  = 5;
    localparam int unsigned SW6  = 6;
    localparam int unsigned SW7  = 7;
    localparam int unsigned SW8  = 8;
    localparam int unsigned SW9  = 9;
    localparam int unsigned SW10 = 10;
    localparam int unsigned SW11 = 11;
    localparam int unsigned SW12 = 12;
    localparam int unsigned SW13 = 13;
    localparam int unsigned SW14 = 14;
    localparam int unsigned SW15 = 15;
    localparam int unsigned BTNC = 16;
    localparam int unsigned BTNU = 17;
    localparam int unsigned BTNL = 18;
    localparam int unsigned BTNR = 19;
    localparam int unsigned BTND = 20;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, stability counter FSM,
// registered level and single-cycle rise/fall pulses.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk100m,
    input  logic rstn,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk100m) begin
        if (!rstn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= DB_STABLE;
            count_q <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // count holds the number of consecutive mismatch edges seen so far.
    always_comb begin
        s1_d    = raw_in;
        s2_d    = s1_q;
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_STABLE: begin
                count_d = '0;
                if (s2_q != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d = s2_q;
                        rise_d  = s2_q;
                        fall_d  = ~s2_q;
                    end else begin
                        state_d = DB_PENDING;
                        count_d = CNT_W'(1);
                    end
                end
            end
            DB_PENDING: begin
                if (s2_q == level_q) begin
                    state_d = DB_STABLE;
                    count_d = '0;
                end else if (count_q == CNT_LAST) begin
                    level_d = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                    state_d = DB_STABLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                count_d = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/board_input_debounce.sv
// Conditions raw switch/button pins into clean clk100m-domain levels and
// edge pulses, one independent debounce channel per pin.
module board_input_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned WIDTH           = N_SW + N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic             clk100m,
    input  logic             rstn,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_event
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk100m (clk100m),
            .rstn    (rstn),
            .raw_in  (raw_in[i]),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // Combinational from registered pulses, so it coincides with them.
    assign any_event = |(rise | fall);

endmodule
